argmax_classifier: RTL and testbench

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

---
 rtl/argmax_classifier.sv | 114 +++++++++++
 tb/tb_argmax_classifier.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
// Streaming argmax: collects up to N_CLASSES signed scores per frame and reports
// the index and value of the largest one, flagging frames of the wrong length.
module argmax_classifier #(
  parameter int N_CLASSES = 10,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_class,
  output logic [DATA_W-1:0] out_score,
  output logic              frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] max_q, max_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  class_q, class_d;
  logic [DATA_W-1:0] score_q, score_d;
  logic              err_q, err_d;

  logic              beat;
  logic              at_last;
  logic              closing;
  logic              take;
  logic [DATA_W-1:0] cand_max;
  logic [IDX_W-1:0]  cand_idx;

  assign beat    = in_valid & in_ready;
  assign at_last = (cnt_q == LAST_IDX);
  assign closing = beat & (in_last | at_last);
  // First beat loads unconditionally; strict > keeps the lower index on ties.
  assign take     = (cnt_q == '0) | ($signed(in_data) > $signed(max_q));
  assign cand_max = take ? in_data : max_q;
  assign cand_idx = take ? cnt_q : idx_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (closing)   state_d = HOLD;
      HOLD:    if (out_ready) state_d = COLLECT;
      default:                state_d = COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == HOLD);
  end

  always_comb begin
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    class_d = class_q;
    score_d = score_q;
    err_d   = err_q;
    if (beat) begin
      if (closing) begin
        cnt_d   = '0;
        class_d = cand_idx;
        score_d = cand_max;
        // Closing on in_last alone is short; closing on count alone is long.
        err_d   = in_last ^ at_last;
      end else begin
        cnt_d = cnt_q + 1'b1;
        max_d = cand_max;
        idx_d = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      class_q <= '0;
      score_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      class_q <= class_d;
      score_q <= score_d;
      err_q   <= err_d;
    end
  end

  assign out_class = class_q;
  assign out_score = score_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: expected results are queued as frames
// are driven and compared whenever the DUT hands a result over.
module tb_argmax_classifier;
  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [IW-1:0] out_class;
  logic [DW-1:0] out_score;
  logic          frame_err;

  argmax_classifier #(.N_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk       (clk),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] cls;
    logic [DW-1:0] score;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            gap_pct = 0;
  logic [DW-1:0] frame_data [N];
  int            frame_len;
  logic          frame_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (RST && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result: class=%0d score=%0h err=%0b (exp class=%0d score=%0h err=%0b)",
                 out_class, out_score, frame_err, e.cls, e.score, e.err);
        check_eq("out_class", 32'(out_class), 32'(e.cls));
        check_eq("out_score", 32'(out_score), 32'(e.score));
        check_eq("frame_err", 32'(frame_err), 32'(e.err));
      end
    end
  end

  // Entry and exit aligned 1 time unit after a rising edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int waited = 0;
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 50) begin
        check_eq("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input bit drain);
    int   best = 0;
    exp_t e;
    for (int i = 1; i < frame_len; i++)
      if ($signed(frame_data[i]) > $signed(frame_data[best])) best = i;
    e.cls   = IW'(best);
    e.score = frame_data[best];
    e.err   = frame_last ? (frame_len < N) : (frame_len == N);
    exp_q.push_back(e);
    for (int i = 0; i < frame_len; i++)
      send_beat(frame_data[i], frame_last && (i == frame_len - 1));
    @(negedge clk);
    check_eq("latency_out_valid", 32'(out_valid), 32'd1);
    if (drain) wait_drain();
  endtask

  task automatic load_frame(input int v0, input int v1, input int v2, input int v3, input int v4,
                            input int v5, input int v6, input int v7, input int v8, input int v9,
                            input int len, input logic last);
    frame_data[0] = 16'(v0); frame_data[1] = 16'(v1); frame_data[2] = 16'(v2);
    frame_data[3] = 16'(v3); frame_data[4] = 16'(v4); frame_data[5] = 16'(v5);
    frame_data[6] = 16'(v6); frame_data[7] = 16'(v7); frame_data[8] = 16'(v8);
    frame_data[9] = 16'(v9);
    frame_len  = len;
    frame_last = last;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_class", 32'(out_class), 32'd0);
    check_eq("rst_out_score", 32'(out_score), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    RST = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic frame, max 9 at index 4
    load_frame(3, -5, 7, 2, 9, 1, 0, 4, 8, 6, 10, 1'b1);
    run_frame(1'b1);

    // All equal negatives: index 0, no zero-init bias
    load_frame(-100, -100, -100, -100, -100, -100, -100, -100, -100, -100, 10, 1'b1);
    run_frame(1'b1);

    // Short frame
    load_frame(1, 2, 3, 12, 5, 6, 0, 0, 0, 0, 6, 1'b1);
    run_frame(1'b1);

    // Single-score short frame
    load_frame(-7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1'b1);
    run_frame(1'b1);

    // Same data with random gaps
    gap_pct = 50;
    load_frame(3, -5, 7, 2, 9, 1, 0, 4, 8, 6, 10, 1'b1);
    run_frame(1'b1);
    gap_pct = 0;

    // Long frame with back-pressure on the result
    out_ready = 1'b0;
    load_frame(-300, 200, 5, -1, 17, 1000, -32768, 44, 32766, 32767, 10, 1'b0);
    run_frame(1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("hold_out_valid", 32'(out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_out_class", 32'(out_class), 32'd9);
      check_eq("hold_out_score", 32'(out_score), 32'h7FFF);
      check_eq("hold_frame_err", 32'(frame_err), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    // Next frame must start from cnt=0
    load_frame(3, -5, 7, 2, 9, 1, 0, 4, 8, 6, 10, 1'b1);
    run_frame(1'b1);

    // Reset mid-frame after 5 large beats
    for (int i = 0; i < 5; i++) send_beat(16'd30000, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_out_class", 32'(out_class), 32'd0);
    check_eq("midrst_out_score", 32'(out_score), 32'd0);
    check_eq("midrst_frame_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    RST = 1'b1;
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    load_frame(10, 20, -30, 40, 50, 60, 700, 80, 90, 100, 10, 1'b1);
    run_frame(1'b1);

    // Random frames of random length with gaps
    gap_pct = 30;
    for (int f = 0; f < 20; f++) begin
      int len;
      len = int'($urandom_range(1, N));
      for (int i = 0; i < N; i++) frame_data[i] = 16'($urandom_range(0, 65535));
      if (f % 4 == 0) for (int i = 0; i < N; i++) frame_data[i] = 16'(int'($urandom_range(0, 6)) - 3);
      frame_len  = len;
      frame_last = (len < N) ? 1'b1 : 1'($urandom);
      run_frame(1'b1);
    end
    gap_pct = 0;

    repeat (5) @(posedge clk);
    #1;
    check_eq("leftover_results", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
